// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: NOP encoding, skid-stage
// state encoding and default payload widths.
package pipe_pkg;

   localparam int unsigned DEFAULT_INSTR_W = 32;
   localparam int unsigned DEFAULT_PC_W    = 32;

   // RV32I addi x0,x0,0
   localparam logic [31:0] NOP_RV32I = 32'h0000_0013;

   typedef logic [1:0] skid_state_t;

   localparam skid_state_t ST_EMPTY = 2'd0;
   localparam skid_state_t ST_ONE   = 2'd1;
   localparam skid_state_t ST_FULL  = 2'd2;

endpackage

// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline register with a 2-entry skid buffer: in_ready depends only on
// registered state, so decode back-pressure never reaches fetch combinationally.
module if_id_skid_stage
   import pipe_pkg::*;
#(
   parameter int unsigned          INSTR_W   = DEFAULT_INSTR_W,
   parameter int unsigned          PC_W      = DEFAULT_PC_W,
   parameter int unsigned          SIDE_W    = 1,
   parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(NOP_RV32I)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic [PC_W-1:0]    in_pc,
   input  logic [SIDE_W-1:0]  in_side,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [PC_W-1:0]    out_pc,
   output logic [SIDE_W-1:0]  out_side,
   output logic [1:0]         occupancy
);

   skid_state_t        state_q, state_d;
   logic [INSTR_W-1:0] main_instr_q, main_instr_d, skid_instr_q, skid_instr_d;
   logic [PC_W-1:0]    main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
   logic [SIDE_W-1:0]  main_side_q, main_side_d, skid_side_q, skid_side_d;
   logic               in_fire, out_fire;

   assign in_ready  = (state_q != ST_FULL);
   assign out_valid = (state_q != ST_EMPTY);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   // Main slot may hold a stale payload after draining, so mask it when empty.
   assign out_instr = out_valid ? main_instr_q : NOP_INSTR;
   assign out_pc    = out_valid ? main_pc_q    : '0;
   assign out_side  = out_valid ? main_side_q  : '0;

   always_comb begin
      occupancy = 2'd0;
      case (state_q)
         ST_ONE:  occupancy = 2'd1;
         ST_FULL: occupancy = 2'd2;
         default: occupancy = 2'd0;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      main_instr_d = main_instr_q;
      main_pc_d    = main_pc_q;
      main_side_d  = main_side_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;
      skid_side_d  = skid_side_q;

      case (state_q)
         ST_EMPTY: begin
            if (in_fire) begin
               state_d      = ST_ONE;
               main_instr_d = in_instr;
               main_pc_d    = in_pc;
               main_side_d  = in_side;
            end
         end
         ST_ONE: begin
            if (in_fire && out_fire) begin
               main_instr_d = in_instr;
               main_pc_d    = in_pc;
               main_side_d  = in_side;
            end else if (out_fire) begin
               state_d = ST_EMPTY;
            end else if (in_fire) begin
               state_d      = ST_FULL;
               skid_instr_d = in_instr;
               skid_pc_d    = in_pc;
               skid_side_d  = in_side;
            end
         end
         ST_FULL: begin
            if (out_fire) begin
               state_d      = ST_ONE;
               main_instr_d = skid_instr_q;
               main_pc_d    = skid_pc_q;
               main_side_d  = skid_side_q;
            end
         end
         default: state_d = ST_EMPTY;
      endcase

      // Flush wins over any handshake in the same cycle.
      if (flush) begin
         state_d      = ST_EMPTY;
         main_instr_d = NOP_INSTR;
         main_pc_d    = '0;
         main_side_d  = '0;
         skid_instr_d = NOP_INSTR;
         skid_pc_d    = '0;
         skid_side_d  = '0;
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q      <= ST_EMPTY;
         main_instr_q <= NOP_INSTR;
         main_pc_q    <= '0;
         main_side_q  <= '0;
         skid_instr_q <= NOP_INSTR;
         skid_pc_q    <= '0;
         skid_side_q  <= '0;
      end else begin
         state_q      <= state_d;
         main_instr_q <= main_instr_d;
         main_pc_q    <= main_pc_d;
         main_side_q  <= main_side_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
         skid_side_q  <= skid_side_d;
      end
   end

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Scoreboard bench for if_id_skid_stage: a queue model of held entries is
// compared against the DUT every cycle, plus a directed list of consumed PCs.
module tb_if_id_skid_stage;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [2:0]  side;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic [2:0]  in_side;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [2:0]  out_side;
   logic [1:0]  occupancy;

   int errors = 0;
   int checks = 0;

   ent_t        q[$];
   logic [31:0] log_pc[$];
   logic        fire_in, fire_out;
   logic [31:0] exp_pcs [11] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14,
                                 32'h18, 32'h2C, 32'h30, 32'h3C, 32'h40};

   if_id_skid_stage #(
      .INSTR_W (32),
      .PC_W    (32),
      .SIDE_W  (3)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_instr  (in_instr),
      .in_pc     (in_pc),
      .in_side   (in_side),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_pc    (out_pc),
      .out_side  (out_side),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compare against the model, then advance the model with this cycle's inputs.
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
         chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
         chk("occupancy", 64'(occupancy), 64'(q.size()));
         if (q.size() != 0) begin
            chk("out_instr", 64'(out_instr), 64'(q[0].instr));
            chk("out_pc", 64'(out_pc), 64'(q[0].pc));
            chk("out_side", 64'(out_side), 64'(q[0].side));
         end else begin
            chk("idle_instr", 64'(out_instr), 64'h13);
            chk("idle_pc", 64'(out_pc), 64'h0);
            chk("idle_side", 64'(out_side), 64'h0);
         end
         fire_out = (q.size() != 0) && out_ready;
         fire_in  = in_valid && (q.size() < 2);
         if (fire_out) log_pc.push_back(q[0].pc);
         if (flush) begin
            q.delete();
         end else begin
            if (fire_out) void'(q.pop_front());
            if (fire_in) q.push_back('{instr: in_instr, pc: in_pc, side: in_side});
         end
      end
   end

   task automatic step(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [2:0] side, input logic ordy, input logic fl);
      in_valid  = v;
      in_instr  = instr;
      in_pc     = pc;
      in_side   = side;
      out_ready = ordy;
      flush     = fl;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end

   initial begin
      rst_n     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = '0;
      in_pc     = '0;
      in_side   = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;

      // First entry, held under stall, then dropped by a mid-cycle reset.
      step(1'b1, 32'h0050_0093, 32'h0, 3'd0, 1'b0, 1'b0);
      step(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
      chk("first_instr", 64'(out_instr), 64'h0050_0093);
      #2 rst_n = 1'b1;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'h0);
      chk("rst_out_instr", 64'(out_instr), 64'h13);
      chk("rst_out_pc", 64'(out_pc), 64'h0);
      chk("rst_out_side", 64'(out_side), 64'h0);
      chk("rst_in_ready", 64'(in_ready), 64'h1);
      chk("rst_occupancy", 64'(occupancy), 64'h0);
      q.delete();
      @(posedge clk);
      #1 rst_n = 1'b0;

      // Streaming at full rate.
      step(1'b1, 32'hA000_0000, 32'h00, 3'd1, 1'b1, 1'b0);
      step(1'b1, 32'hA000_0004, 32'h04, 3'd2, 1'b1, 1'b0);
      step(1'b1, 32'hA000_0008, 32'h08, 3'd3, 1'b1, 1'b0);
      step(1'b1, 32'hA000_000C, 32'h0C, 3'd4, 1'b1, 1'b0);
      step(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 1'b0);

      // Back-pressure: 0x14 lands in the skid slot, 0x18 waits upstream.
      step(1'b1, 32'hA000_0010, 32'h10, 3'd0, 1'b0, 1'b0);
      step(1'b1, 32'hA000_0014, 32'h14, 3'd0, 1'b0, 1'b0);
      step(1'b1, 32'hA000_0018, 32'h18, 3'd0, 1'b0, 1'b0);
      chk("bp_occupancy", 64'(occupancy), 64'h2);
      chk("bp_in_ready", 64'(in_ready), 64'h0);
      chk("bp_out_pc", 64'(out_pc), 64'h10);
      step(1'b1, 32'hA000_0018, 32'h18, 3'd0, 1'b0, 1'b0);
      step(1'b1, 32'hA000_0018, 32'h18, 3'd0, 1'b1, 1'b0);
      step(1'b1, 32'hA000_0018, 32'h18, 3'd0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 1'b0);

      // Flush while full; 0x28 is dropped, 0x2C follows normally.
      step(1'b1, 32'hA000_0020, 32'h20, 3'd0, 1'b0, 1'b0);
      step(1'b1, 32'hA000_0024, 32'h24, 3'd0, 1'b0, 1'b0);
      step(1'b1, 32'hA000_0028, 32'h28, 3'd0, 1'b0, 1'b1);
      chk("flush_out_valid", 64'(out_valid), 64'h0);
      chk("flush_occupancy", 64'(occupancy), 64'h0);
      step(1'b1, 32'hA000_002C, 32'h2C, 3'd0, 1'b0, 1'b0);
      step(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 1'b0);

      // In ONE with in_fire, out_fire and flush together.
      step(1'b1, 32'hA000_0030, 32'h30, 3'd0, 1'b0, 1'b0);
      step(1'b1, 32'hA000_0034, 32'h34, 3'd0, 1'b1, 1'b1);
      step(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 1'b0);

      // Back-to-back flush from empty.
      step(1'b1, 32'hA000_0038, 32'h38, 3'd0, 1'b1, 1'b1);
      step(1'b1, 32'hA000_0038, 32'h38, 3'd0, 1'b1, 1'b1);
      step(1'b1, 32'hA000_003C, 32'h3C, 3'd0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 1'b0);

      // Sideband with one stall cycle.
      step(1'b1, 32'hA000_0040, 32'h40, 3'b101, 1'b0, 1'b0);
      chk("side_val", 64'(out_side), 64'h5);
      step(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
      chk("side_stall", 64'(out_side), 64'h5);
      step(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 1'b0);
      chk("side_idle", 64'(out_side), 64'h0);
      step(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 1'b0);

      chk("consumed_count", 64'(log_pc.size()), 64'd11);
      for (int i = 0; i < 11; i++) begin
         if (i < log_pc.size()) chk("consumed_pc", 64'(log_pc[i]), 64'(exp_pcs[i]));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/if_id_skid_stage.md
Name: if_id_skid_stage

Overview:
Parametrised successor to the IF/ID pipeline register. It carries instruction, PC and a sideband field from fetch to decode using a valid/ready handshake and a 2-entry skid buffer. This breaks the combinational path from decode back-pressure to fetch. Flush inserts NOP bubbles; the entry count is exported for hazard and performance logic.

Parameters:
INSTR_W, 32, instruction width in bits
PC_W, 32, PC width in bits
SIDE_W, 1, sideband width (e.g. predicted-taken bit); must be >= 1
NOP_INSTR, 32'h0000_0013, encoding driven on out_instr whenever out_valid=0 (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset; one clock; reset is asynchronous and active-high (asserted = 1, despite the name)
flush  in  1  synchronous squash of all held entries
in_valid  in  1  fetch presents an entry
in_ready  out  1  stage can accept an entry
in_instr  in  INSTR_W  fetched instruction
in_pc  in  PC_W  fetched PC
in_side  in  SIDE_W  fetch sideband
out_valid  out  1  decode entry valid
out_ready  in  1  decode accepts entry
out_instr  out  INSTR_W  instruction to decode
out_pc  out  PC_W  PC to decode
out_side  out  SIDE_W  sideband to decode
occupancy  out  2  number of held entries (0..2)

Behaviour:
- Storage: main slot (drives outputs) and skid slot. States: EMPTY (0 entries), ONE (main valid), FULL (main + skid valid). occupancy = 0/1/2 to match.
- Handshake fires: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = (state != FULL). It is a function of registered state only, with no combinational path from out_ready.
- out_valid = (state != EMPTY). When out_valid=0: out_instr = NOP_INSTR, out_pc = 0, out_side = 0.
- Transitions (no flush):
  - EMPTY: in_fire -> ONE, main <= in. Otherwise stay in EMPTY.
  - ONE, in_fire & out_fire: stay in ONE, main <= in.
  - ONE, out_fire only: -> EMPTY.
  - ONE, in_fire only: -> FULL, skid <= in, main unchanged.
  - ONE, neither: hold.
  - FULL: out_fire -> ONE, main <= skid. Otherwise hold. in_fire cannot occur in FULL.
- Latency: 1 cycle from in_fire to out_valid when the stage is empty. Throughput is 1 entry/cycle while out_ready=1.
- Ordering: strict FIFO. The skid entry is never presented before the main entry.
- Stability: while out_valid=1 and out_ready=0, out_instr, out_pc and out_side hold constant.
- Flush: at the next edge, state <= EMPTY and the slot payloads <= NOP_INSTR/0/0.
  - Flush dominates in the same cycle. An in_fire during flush is discarded; an out_fire during flush counts as consumed by decode.
  - in_ready is not masked by flush.
- Back-to-back flush: the stage stays EMPTY. The first post-flush entry is accepted in the cycle after flush deasserts.
- Reset:
  - While rst_n=1 (asynchronous), state = EMPTY, both slots = NOP_INSTR/0/0.
  - Outputs during reset: out_valid=0, in_ready=1, occupancy=0, out_instr=NOP_INSTR, out_pc=0, out_side=0.
  - Reset mid-transfer drops all entries; no partial state survives.
- Widths: payloads are copied verbatim with no arithmetic. occupancy never exceeds 2.
- Illegal-state encoding, if reached: treated as EMPTY at the next edge (default arm).

Decomposition:
- Shared package pipe_pkg: NOP_INSTR constant (RV32I addi x0,x0,0), the 2-bit state enum {EMPTY, ONE, FULL}, and a PC_W/INSTR_W default localparam used by the other stage registers.
- No sub-module is required. The control FSM and the two slot registers are inline. Later ID/EX and EX/MEM successors reuse the same pattern by instantiating if_id_skid_stage with wider SIDE_W.

Test Plan:
- Reset: rst_n=1 asserted mid-cycle -> immediately out_valid=0, out_instr=32'h00000013, out_pc=0, in_ready=1, occupancy=0. Release rst_n, then in_valid=1 with instr 32'h00500093, pc 0x0 -> next cycle out_valid=1, out_instr=32'h00500093.
- Streaming: out_ready=1, feed PCs 0x0, 0x4, 0x8, 0xC on consecutive cycles -> outputs appear 1 cycle later in order, no gaps, occupancy stays at 1.
- Back-pressure: hold out_ready=0 after PC 0x10 is presented, feed 0x14 then 0x18.
  - 0x14 goes to the skid slot; occupancy=2; in_ready=0.
  - 0x18 is held upstream.
  - Raise out_ready: outputs 0x10, 0x14, 0x18 in order; out_pc stays stable at 0x10 throughout the stall.
- Flush while FULL (0x20, 0x24 held) with in_valid=1 on 0x28 -> next cycle out_valid=0, out_instr=NOP, occupancy=0. The entry 0x28 is dropped; 0x2C, presented after the flush, appears normally.
- Simultaneous in_fire and out_fire in ONE state with flush=1 -> state EMPTY. The out entry counts as consumed; the in entry is discarded.
- Sideband: SIDE_W=3, in_side=3'b101 on PC 0x40 with one stall cycle -> out_side=3'b101 exactly while out_pc=0x40; out_side=0 whenever out_valid=0.
